fft_r4_seq: RTL and testbench

In-place, memory-based radix-4 DIT FFT sequencer that schedules the shared pipelined radix-4 butterfly. It walks all stages of an N = 4^LOG4N point transform. For each butterfly it issues four data-memory read addresses and three twiddle-ROM addresses, pulses the butterfly start, and writes the four results back to the same addresses once the fixed pipeline latency has elapsed. It sits between the top-level FFT control (go/done) and the data memory, twiddle ROM and butterfly.

---
 rtl/fft_r4_seq.sv | 191 +++++++++++++++++++
 tb/tb_fft_r4_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fft_r4_seq.sv
// rtl/fft_r4_seq.sv - in-place radix-4 DIT FFT butterfly sequencer (optional cycle counter: FFT_SEQ_CYCLE_CNT_EN)
module fft_r4_seq #(
    parameter int  LOG4N  = 3,
    parameter int  RD_LAT = 1,
    parameter int  BF_LAT = 5,
    localparam int AW     = 2 * LOG4N,
    localparam int SW     = (LOG4N > 1) ? $clog2(LOG4N) : 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_go,
    output logic          o_busy,
    output logic          o_fft_done,
    output logic [SW-1:0] o_stage,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr0,
    output logic [AW-1:0] o_rd_addr1,
    output logic [AW-1:0] o_rd_addr2,
    output logic [AW-1:0] o_rd_addr3,
    output logic [AW-1:0] o_tw_addr0,
    output logic [AW-1:0] o_tw_addr1,
    output logic [AW-1:0] o_tw_addr2,
    output logic          o_bf_start,
    input  logic          i_bf_done,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr0,
    output logic [AW-1:0] o_wr_addr1,
    output logic [AW-1:0] o_wr_addr2,
    output logic [AW-1:0] o_wr_addr3,
    output logic          o_sync_err
`ifdef FFT_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]   o_cycle_cnt
`endif
);

    localparam int D   = RD_LAT + BF_LAT;
    localparam int BW  = (AW > 2) ? AW - 2 : 1;
    localparam int NB  = 1 << BW;
    localparam int DCW = $clog2(D + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t                    r_state;
    logic [SW-1:0]             r_stage;
    logic [BW-1:0]             r_b;
    logic [DCW-1:0]            r_dcnt;
    logic                      r_busy;
    logic                      r_fft_done;
    logic                      r_rd_en;
    logic [3:0][AW-1:0]        r_rd_addr;
    logic [2:0][AW-1:0]        r_tw;
    logic [D-1:0]              r_pv;
    logic [D-1:0][3:0][AW-1:0] r_pa;
    logic                      r_sync_err;
    logic                      w_go_acc;

    assign w_go_acc = i_go && (r_state == S_IDLE || r_state == S_FIN);

    // Butterfly b of stage s reads base + m*Q, base = (b/Q)*4Q + b%Q, Q = 4^s
    function automatic logic [AW-1:0] f_rd(input logic [SW-1:0] s, input logic [BW-1:0] b, input int m);
        logic [AW-1:0] q, j, g;
        q = AW'(1) << (2 * s);
        j = AW'(b) & (q - AW'(1));
        g = AW'(b) >> (2 * s);
        return (g << (2 * s + 2)) + j + AW'(m) * q;
    endfunction

    function automatic logic [AW-1:0] f_tw(input logic [SW-1:0] s, input logic [BW-1:0] b, input int m);
        logic [AW-1:0] q, k;
        q = AW'(1) << (2 * s);
        k = (AW'(b) & (q - AW'(1))) << (2 * (LOG4N - 1 - int'(s)));
        return k * AW'(m + 1);
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_b        <= '0;
            r_dcnt     <= '0;
            r_busy     <= 1'b0;
            r_fft_done <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_tw       <= '0;
        end else begin
            r_fft_done <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_tw       <= '0;
            case (r_state)
                S_IDLE, S_FIN: begin
                    r_state <= S_IDLE;
                    if (w_go_acc) begin
                        r_state <= S_ISSUE;
                        r_stage <= '0;
                        r_b     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        for (int m = 0; m < 4; m++) r_rd_addr[m] <= f_rd('0, '0, m);
                        for (int m = 0; m < 3; m++) r_tw[m] <= f_tw('0, '0, m);
                    end
                end
                S_ISSUE: begin
                    if (r_b == BW'(NB - 1)) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                    end else begin
                        r_b     <= r_b + 1'b1;
                        r_rd_en <= 1'b1;
                        for (int m = 0; m < 4; m++) r_rd_addr[m] <= f_rd(r_stage, r_b + 1'b1, m);
                        for (int m = 0; m < 3; m++) r_tw[m] <= f_tw(r_stage, r_b + 1'b1, m);
                    end
                end
                S_DRAIN: begin
                    // Hold off reads until every write of this stage has landed
                    if (r_dcnt == DCW'(D - 1)) begin
                        if (r_stage == SW'(LOG4N - 1)) begin
                            r_state    <= S_FIN;
                            r_busy     <= 1'b0;
                            r_fft_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_stage <= r_stage + 1'b1;
                            r_b     <= '0;
                            r_rd_en <= 1'b1;
                            for (int m = 0; m < 4; m++) r_rd_addr[m] <= f_rd(r_stage + 1'b1, '0, m);
                            for (int m = 0; m < 3; m++) r_tw[m] <= f_tw(r_stage + 1'b1, '0, m);
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pv <= '0;
            r_pa <= '0;
        end else begin
            r_pv <= {r_pv[D-2:0], r_rd_en};
            r_pa <= {r_pa[D-2:0], r_rd_addr};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync_err <= 1'b0;
        end else if (i_bf_done != r_pv[D-1]) begin
            r_sync_err <= 1'b1;
        end
    end

`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset || w_go_acc) begin
            r_cycle_cnt <= '0;
        end else if (r_busy) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
`endif

    assign o_busy     = r_busy;
    assign o_fft_done = r_fft_done;
    assign o_stage    = r_stage;
    assign o_rd_en    = r_rd_en;
    assign o_rd_addr0 = r_rd_addr[0];
    assign o_rd_addr1 = r_rd_addr[1];
    assign o_rd_addr2 = r_rd_addr[2];
    assign o_rd_addr3 = r_rd_addr[3];
    assign o_tw_addr0 = r_tw[0];
    assign o_tw_addr1 = r_tw[1];
    assign o_tw_addr2 = r_tw[2];
    assign o_bf_start = r_pv[RD_LAT-1];
    assign o_wr_en    = r_pv[D-1];
    assign o_wr_addr0 = r_pa[D-1][0];
    assign o_wr_addr1 = r_pa[D-1][1];
    assign o_wr_addr2 = r_pa[D-1][2];
    assign o_wr_addr3 = r_pa[D-1][3];
    assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_fft_r4_seq.sv
// tb/tb_fft_r4_seq.sv - self-checking bench for fft_r4_seq (default N=64, D=6)
module tb_fft_r4_seq;

    logic       clk = 1'b0;
    logic       reset, go, bf_done;
    logic       busy, fft_done, rd_en, bf_start, wr_en, sync_err;
    logic [1:0] stage;
    logic [5:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [5:0] tw_addr0, tw_addr1, tw_addr2;
    logic [5:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif
    logic [4:0] r_dl;
    bit         tie0 = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    fft_r4_seq dut (
        .i_clock(clk), .i_reset(reset), .i_go(go),
        .o_busy(busy), .o_fft_done(fft_done), .o_stage(stage),
        .o_rd_en(rd_en),
        .o_rd_addr0(rd_addr0), .o_rd_addr1(rd_addr1), .o_rd_addr2(rd_addr2), .o_rd_addr3(rd_addr3),
        .o_tw_addr0(tw_addr0), .o_tw_addr1(tw_addr1), .o_tw_addr2(tw_addr2),
        .o_bf_start(bf_start), .i_bf_done(bf_done),
        .o_wr_en(wr_en),
        .o_wr_addr0(wr_addr0), .o_wr_addr1(wr_addr1), .o_wr_addr2(wr_addr2), .o_wr_addr3(wr_addr3),
        .o_sync_err(sync_err)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        , .o_cycle_cnt(cycle_cnt)
`endif
    );

    // Ideal butterfly: done follows start by exactly 5 cycles
    always @(posedge clk) begin
        if (reset) r_dl <= '0;
        else       r_dl <= {r_dl[3:0], bf_start};
    end
    assign bf_done = tie0 ? 1'b0 : r_dl[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected issue at cycle r after go: {valid, a3..a0, w2..w0}, 6 bits per field
    function automatic logic [42:0] exp_rd(input int r);
        int s, i, q, j, g, base, k;
        logic [42:0] e;
        e = '0;
        if (r >= 1 && r <= 66) begin
            s = (r - 1) / 22;
            i = (r - 1) % 22;
            if (i < 16) begin
                q    = 1 << (2 * s);
                j    = i % q;
                g    = i / q;
                base = g * 4 * q + j;
                k    = j * (1 << (2 * (2 - s)));
                e[42] = 1'b1;
                for (int m = 0; m < 4; m++) e[18 + 6*m +: 6] = 6'(base + m * q);
                for (int m = 0; m < 3; m++) e[6*m +: 6] = 6'((m + 1) * k);
            end
        end
        return e;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
        chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        chk({tag, "_bf_start"}, 64'(bf_start), 64'(0));
        chk({tag, "_fft_done"}, 64'(fft_done), 64'(0));
        chk({tag, "_sync_err"}, 64'(sync_err), 64'(0));
        chk({tag, "_stage"}, 64'(stage), 64'(0));
        chk({tag, "_rd_tw_addr"}, 64'({rd_addr3, rd_addr2, rd_addr1, rd_addr0, tw_addr2, tw_addr1, tw_addr0}), 64'(0));
        chk({tag, "_wr_addr"}, 64'({wr_addr3, wr_addr2, wr_addr1, wr_addr0}), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic run(input bit tie, input int ncyc, input int rst_at, input int again_at, input bit rnd_go);
        int base, rel, wr_cnt;
        logic [42:0] e, ew, eb;
        tie0 = tie;
        @(negedge clk);
        chk("pre_go_busy", 64'(busy), 64'(0));
        go = 1'b1;
        base = 0;
        wr_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            go = 1'b0;
            reset = 1'b0;
            rel = c - base;
            if (rst_at > 0 && c > rst_at) begin
                check_idle("after_reset");
            end else begin
                e  = exp_rd(rel);
                eb = exp_rd(rel - 1);
                ew = exp_rd(rel - 6);
                if (wr_en) wr_cnt++;
                chk("rd_en", 64'(rd_en), 64'(e[42]));
                if (e[42]) begin
                    chk("rd_addr", 64'({rd_addr3, rd_addr2, rd_addr1, rd_addr0}), 64'(e[41:18]));
                    chk("tw_addr", 64'({tw_addr2, tw_addr1, tw_addr0}), 64'(e[17:0]));
                end
                chk("bf_start", 64'(bf_start), 64'(eb[42]));
                chk("wr_en", 64'(wr_en), 64'(ew[42]));
                if (ew[42])
                    chk("wr_addr", 64'({wr_addr3, wr_addr2, wr_addr1, wr_addr0}), 64'(ew[41:18]));
                chk("busy", 64'(busy), 64'(rel >= 1 && rel <= 66));
                chk("fft_done", 64'(fft_done), 64'(rel == 67));
                if (rel >= 1 && rel <= 66) chk("stage", 64'(stage), 64'((rel - 1) / 22));
                chk("sync_err", 64'(sync_err), 64'(tie && rel >= 8));
                if (rel == 67) begin
                    chk("wr_count", 64'(wr_cnt), 64'(48));
`ifdef FFT_SEQ_CYCLE_CNT_EN
                    chk("cycle_cnt", 64'(cycle_cnt), 64'(66));
`endif
                    wr_cnt = 0;
                end
            end
            if (c == rst_at) begin
                reset = 1'b1;
            end else if (c == again_at) begin
                go = 1'b1;
                base = c;
            end else if (rnd_go && (c == 30 || (rel >= 1 && rel <= 65 && $urandom_range(0, 3) == 0))) begin
                go = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
        repeat ($urandom_range(1, 5)) @(negedge clk);
        run(1'b0, 134, 0, 67, 1'b1);
        do_reset();
        run(1'b1, 67, 0, 0, 1'b0);
        do_reset();
        run(1'b0, 40, 20, 0, 1'b0);
        run(1'b0, 67, 0, 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
